// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_sched_pkg
// Description : Shared types and helpers for the convolution scheduler:
//               FSM state encoding, internal offset width and the
//               job-configuration validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_sched_pkg;

  // Offset sums stay within 7+7+7 = 21, so 5 bits never overflow.
  localparam int OFF_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    MAC   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A job needs at least one tap, one IF word, a non-zero stride and a
  // filter that fits inside the IF row.
  function automatic logic cfg_valid(input logic [2:0] f,
                                     input logic [2:0] n,
                                     input logic       stride_nz);
    return (f != 3'd0) && (n != 3'd0) && stride_nz && (f <= n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_scheduler_if
// Description : Job configuration, producer availability and datapath control
//               bundle of the convolution scheduler.
//   master : scheduler side (consumes config/avail, drives addresses/enables)
//   slave  : environment side (drives config/avail, observes the scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_scheduler_if #(
  parameter int IF_ADDRESS_SIZE     = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int STRIDE_SIZE         = 2
);
  logic                       start;
  logic [STRIDE_SIZE:0]       stride;
  logic [2:0]                 filter_size;
  logic [2:0]                 if_size;
  logic [IF_ADDRESS_SIZE:0]   if_base;
  logic [IF_ADDRESS_SIZE:0]   psum_base;
  logic [FILTER_ADDRESS_SIZE:0] filter_base;
  logic [IF_ADDRESS_SIZE:0]   if_avail;
  logic [FILTER_ADDRESS_SIZE:0] filter_avail;

  logic [IF_ADDRESS_SIZE:0]   if_rd_addr;
  logic [FILTER_ADDRESS_SIZE:0] filter_rd_addr;
  logic                       mac_en;
  logic                       mac_first;
  logic                       mac_last;
  logic                       psum_wr_en;
  logic [IF_ADDRESS_SIZE:0]   psum_wr_addr;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    input  start, stride, filter_size, if_size, if_base, psum_base,
           filter_base, if_avail, filter_avail,
    output if_rd_addr, filter_rd_addr, mac_en, mac_first, mac_last,
           psum_wr_en, psum_wr_addr, busy, done, err
  );

  modport slave (
    output start, stride, filter_size, if_size, if_base, psum_base,
           filter_base, if_avail, filter_avail,
    input  if_rd_addr, filter_rd_addr, mac_en, mac_first, mac_last,
           psum_wr_en, psum_wr_addr, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/conv_sched_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_sched_addr_gen
// Description : Window/tap counters of the convolution scheduler. Holds
//               win_off, win_idx and tap, and forms the IF, filter and psum
//               addresses from the counter values of the NEXT cycle so the
//               top can register them, plus last-tap / last-window flags
//               from the current values.
//   clear     : reset all counters (accepted start)
//   mac_step  : advance tap (wraps to 0 after the last tap)
//   win_step  : advance to the next window
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sched_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int IF_ADDRESS_SIZE     = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int STRIDE_SIZE         = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         mac_step,
  input  logic                         win_step,
  input  logic [STRIDE_SIZE:0]         stride,
  input  logic [2:0]                   filter_size,
  input  logic [2:0]                   if_size,
  input  logic [IF_ADDRESS_SIZE:0]     if_base,
  input  logic [IF_ADDRESS_SIZE:0]     psum_base,
  input  logic [FILTER_ADDRESS_SIZE:0] filter_base,
  output logic [OFF_W-1:0]             win_off,
  output logic [2:0]                   nxt_tap,
  output logic [IF_ADDRESS_SIZE:0]     nxt_if_addr,
  output logic [FILTER_ADDRESS_SIZE:0] nxt_filter_addr,
  output logic [IF_ADDRESS_SIZE:0]     nxt_psum_addr,
  output logic                         last_tap,
  output logic                         last_win
);
  localparam int IAW = IF_ADDRESS_SIZE + 1;
  localparam int FAW = FILTER_ADDRESS_SIZE + 1;

  logic [OFF_W-1:0] off_q, off_d;
  logic [OFF_W-1:0] idx_q, idx_d;
  logic [2:0]       tap_q, tap_d;

  assign last_tap = (tap_q == (filter_size - 3'd1));
  assign last_win = ((off_q + OFF_W'(stride) + OFF_W'(filter_size)) > OFF_W'(if_size));

  always_comb begin
    off_d = off_q;
    idx_d = idx_q;
    tap_d = tap_q;
    if (clear) begin
      off_d = '0;
      idx_d = '0;
      tap_d = '0;
    end else begin
      if (mac_step) tap_d = last_tap ? 3'd0 : (tap_q + 3'd1);
      if (win_step) begin
        off_d = off_q + OFF_W'(stride);
        idx_d = idx_q + OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= '0;
      idx_q <= '0;
      tap_q <= '0;
    end else begin
      off_q <= off_d;
      idx_q <= idx_d;
      tap_q <= tap_d;
    end
  end

  assign win_off         = off_q;
  assign nxt_tap         = tap_d;
  // Additions wrap modulo the address width.
  assign nxt_if_addr     = if_base + IAW'(off_d) + IAW'(tap_d);
  assign nxt_filter_addr = filter_base + FAW'(tap_d);
  assign nxt_psum_addr   = psum_base + IAW'(idx_d);

endmodule
`default_nettype wire

// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_scheduler
// Description : Sequencing controller for the convolution datapath. Walks
//               1-D windows with a programmable stride, stalls until the
//               producers have written the needed IF/filter words, drives
//               IF/filter read addresses, MAC enables/framing and one psum
//               write per window. All outputs are registered.
// Ports       : clk, rst_n (async active-low), bus (conv_scheduler_if.master),
//               stall_cycles [15:0] only when CONV_SCHED_STALL_CNT_EN is
//               defined (cycles spent stalled in WAIT, saturating).
// Options     : `define CONV_SCHED_STALL_CNT_EN adds the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IF_ADDRESS_SIZE     = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int STRIDE_SIZE         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_scheduler_if.master bus
`ifdef CONV_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);
  localparam int IAW = IF_ADDRESS_SIZE + 1;
  localparam int FAW = FILTER_ADDRESS_SIZE + 1;

  state_t state, next_state;

  logic [STRIDE_SIZE:0] cfg_stride;
  logic [2:0]           cfg_f, cfg_n;
  logic [IAW-1:0]       cfg_if_base, cfg_psum_base;
  logic [FAW-1:0]       cfg_filter_base;

  logic             start_acc, cfg_ok, ready, last_tap, last_win;
  logic [OFF_W-1:0] win_off, need_if;
  logic [2:0]       nxt_tap;
  logic [IAW-1:0]   nxt_if_addr, nxt_psum_addr;
  logic [FAW-1:0]   nxt_filter_addr;

  assign start_acc = (state == IDLE) && bus.start;
  assign cfg_ok    = cfg_valid(cfg_f, cfg_n, |cfg_stride);
  assign need_if   = win_off + OFF_W'(cfg_f);
  assign ready     = (bus.if_avail >= IAW'(need_if)) && (bus.filter_avail >= FAW'(cfg_f));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_stride      <= '0;
      cfg_f           <= '0;
      cfg_n           <= '0;
      cfg_if_base     <= '0;
      cfg_psum_base   <= '0;
      cfg_filter_base <= '0;
    end else if (start_acc) begin
      cfg_stride      <= bus.stride;
      cfg_f           <= bus.filter_size;
      cfg_n           <= bus.if_size;
      cfg_if_base     <= bus.if_base;
      cfg_psum_base   <= bus.psum_base;
      cfg_filter_base <= bus.filter_base;
    end
  end

  conv_sched_addr_gen #(
    .IF_ADDRESS_SIZE    (IF_ADDRESS_SIZE),
    .FILTER_ADDRESS_SIZE(FILTER_ADDRESS_SIZE),
    .STRIDE_SIZE        (STRIDE_SIZE)
  ) u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (start_acc),
    .mac_step       (state == MAC),
    .win_step       ((state == WRITE) && !last_win),
    .stride         (cfg_stride),
    .filter_size    (cfg_f),
    .if_size        (cfg_n),
    .if_base        (cfg_if_base),
    .psum_base      (cfg_psum_base),
    .filter_base    (cfg_filter_base),
    .win_off        (win_off),
    .nxt_tap        (nxt_tap),
    .nxt_if_addr    (nxt_if_addr),
    .nxt_filter_addr(nxt_filter_addr),
    .nxt_psum_addr  (nxt_psum_addr),
    .last_tap       (last_tap),
    .last_win       (last_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = LOAD;
      LOAD:    next_state = cfg_ok ? WAIT : DONE;
      WAIT:    if (ready) next_state = MAC;
      MAC:     if (last_tap) next_state = WRITE;
      WRITE:   next_state = last_win ? DONE : WAIT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state and next counter values, so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
      bus.mac_en         <= 1'b0;
      bus.mac_first      <= 1'b0;
      bus.mac_last       <= 1'b0;
      bus.psum_wr_en     <= 1'b0;
      bus.if_rd_addr     <= '0;
      bus.filter_rd_addr <= '0;
      bus.psum_wr_addr   <= '0;
    end else begin
      bus.busy           <= (next_state != IDLE);
      bus.done           <= (next_state == DONE);
      bus.mac_en         <= (next_state == MAC);
      bus.mac_first      <= (next_state == MAC) && (nxt_tap == 3'd0);
      bus.mac_last       <= (next_state == MAC) && (nxt_tap == (cfg_f - 3'd1));
      bus.psum_wr_en     <= (next_state == WRITE);
      bus.if_rd_addr     <= (next_state == MAC)   ? nxt_if_addr     : '0;
      bus.filter_rd_addr <= (next_state == MAC)   ? nxt_filter_addr : '0;
      bus.psum_wr_addr   <= (next_state == WRITE) ? nxt_psum_addr   : '0;
      if (start_acc)                   bus.err <= 1'b0;
      else if ((state == LOAD) && !cfg_ok) bus.err <= 1'b1;
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              stall_cycles <= '0;
    else if (start_acc)                                      stall_cycles <= '0;
    else if ((state == WAIT) && !ready && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_conv_scheduler
// Description : Self-checking bench for conv_scheduler. Each job's expected
//               event timeline (MAC taps, psum writes, done cycle, err and
//               stall count) is computed from the window arithmetic and the
//               availability schedule, then compared with what the DUT emits.
//               Honours CONV_SCHED_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_scheduler;
  localparam int IAS = 8;
  localparam int FAS = 8;
  localparam int SS  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_scheduler_if #(.IF_ADDRESS_SIZE(IAS), .FILTER_ADDRESS_SIZE(FAS), .STRIDE_SIZE(SS)) bus ();

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  conv_scheduler #(.IF_ADDRESS_SIZE(IAS), .FILTER_ADDRESS_SIZE(FAS), .STRIDE_SIZE(SS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_flags();
    return 32'({bus.busy, bus.done, bus.err, bus.mac_en, bus.mac_first, bus.mac_last, bus.psum_wr_en});
  endfunction

  function automatic logic [31:0] out_addrs();
    return 32'({bus.if_rd_addr, bus.filter_rd_addr, bus.psum_wr_addr});
  endfunction

  // Run one job. IF availability is if_lo before cycle 'rel' (relative to
  // the start-sampling cycle t = 0) and if_hi from then on.
  task automatic run_job(input int s, input int f, input int n, input int ifb, input int fb,
                         input int pb, input int if_lo, input int if_hi, input int rel,
                         input int fl, input bit pulse);
    logic [31:0] exp_mac[$], obs_mac[$], exp_wr[$], obs_wr[$];
    int exp_done, obs_done, exp_stall, nwin, c, off, busy_bad;
    logic err_obs;
    bit valid;

    // Reference timeline
    valid     = (f != 0) && (n != 0) && (s != 0) && (f <= n);
    exp_stall = 0;
    if (!valid) begin
      exp_done = 2;
    end else begin
      nwin = (n - f) / s + 1;
      c    = 2;
      for (int w = 0; w < nwin; w++) begin
        off = w * s;
        while (!(((c >= rel) ? if_hi : if_lo) >= off + f && fl >= f) && c < 400) begin
          c++;
          exp_stall++;
        end
        for (int tp = 0; tp < f; tp++)
          exp_mac.push_back({2'b0, 10'(c + 1 + tp), 9'(ifb + off + tp), 9'(fb + tp),
                             1'(tp == 0), 1'(tp == f - 1)});
        exp_wr.push_back({13'b0, 10'(c + f + 1), 9'(pb + w)});
        c = c + f + 2;
      end
      exp_done = c;
    end

    // Stimulus and observation
    @(negedge clk);
    bus.stride       = 3'(s);
    bus.filter_size  = 3'(f);
    bus.if_size      = 3'(n);
    bus.if_base      = 9'(ifb);
    bus.filter_base  = 9'(fb);
    bus.psum_base    = 9'(pb);
    bus.if_avail     = 9'((0 >= rel) ? if_hi : if_lo);
    bus.filter_avail = 9'(fl);
    bus.start        = 1'b1;
    obs_done = -1;
    busy_bad = 0;
    err_obs  = 1'b0;
    for (int k = 1; k <= 300 && obs_done < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = pulse && (k == 4 || k == exp_done);
      if (bus.mac_en)
        obs_mac.push_back({2'b0, 10'(k), bus.if_rd_addr, bus.filter_rd_addr, bus.mac_first, bus.mac_last});
      if (bus.psum_wr_en)
        obs_wr.push_back({13'b0, 10'(k), bus.psum_wr_addr});
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        obs_done = k;
        err_obs  = bus.err;
      end
      bus.if_avail = 9'((k >= rel) ? if_hi : if_lo);
    end

    check("done_cycle", obs_done, exp_done);
    check("err", 32'(err_obs), 32'(!valid));
    check("busy_during_job", busy_bad, 0);
    check("mac_count", obs_mac.size(), exp_mac.size());
    for (int i = 0; i < exp_mac.size() && i < obs_mac.size(); i++)
      check("mac_event", obs_mac[i], exp_mac[i]);
    check("psum_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check("psum_event", obs_wr[i], exp_wr[i]);
`ifdef CONV_SCHED_STALL_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
`endif

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("idle_after_job", 32'({bus.busy, bus.done, bus.mac_en, bus.psum_wr_en}), 32'd0);
  endtask

  initial begin
    int s, f, n, lo, seen_done;

    bus.start = 1'b0; bus.stride = '0; bus.filter_size = '0; bus.if_size = '0;
    bus.if_base = '0; bus.filter_base = '0; bus.psum_base = '0;
    bus.if_avail = '0; bus.filter_avail = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_flags", out_flags(), 32'd0);
    check("reset_addrs", out_addrs(), 32'd0);
`ifdef CONV_SCHED_STALL_CNT_EN
    check("reset_stall", 32'(stall_cycles), 32'd0);
`endif
    rst_n = 1'b1;

    // Directed jobs
    run_job(2, 3, 7, 0, 0, 0, 511, 511, 0, 511, 1'b0);      // 3 windows, offsets 0,2,4
    run_job(1, 3, 5, 0, 0, 0, 2, 5, 12, 511, 1'b0);         // stalled for 10 cycles
    run_job(1, 0, 4, 0, 0, 0, 511, 511, 0, 511, 1'b0);      // F=0
    run_job(1, 5, 4, 0, 0, 0, 511, 511, 0, 511, 1'b0);      // F>N
    run_job(0, 2, 4, 0, 0, 0, 511, 511, 0, 511, 1'b0);      // S=0
    run_job(1, 3, 3, 510, 7, 100, 511, 511, 0, 511, 1'b0);  // IF address wrap
    run_job(1, 2, 6, 20, 30, 40, 511, 511, 0, 511, 1'b1);   // start while busy / in DONE

    // Asynchronous reset during the second MAC tap
    @(negedge clk);
    bus.stride = 3'd1; bus.filter_size = 3'd3; bus.if_size = 3'd7;
    bus.if_base = 9'd0; bus.filter_base = 9'd0; bus.psum_base = 9'd0;
    bus.if_avail = 9'd511; bus.filter_avail = 9'd511; bus.start = 1'b1;
    @(posedge clk); @(negedge clk); bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    check("second_tap_addr", 32'({bus.mac_en, bus.if_rd_addr}), 32'({1'b1, 9'd1}));
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", out_flags(), 32'd0);
    check("async_rst_addrs", out_addrs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    check("no_activity_after_rst", seen_done, 0);
    run_job(1, 3, 7, 5, 6, 7, 511, 511, 0, 511, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      s  = int'($urandom_range(0, 7));
      n  = int'($urandom_range(0, 7));
      f  = int'($urandom_range(0, 7));
      lo = int'($urandom_range(0, 7));
      run_job(s, f, n, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 511)), lo, int'($urandom_range(7, 511)),
              int'($urandom_range(0, 15)), int'($urandom_range(7, 511)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_scheduler.md
# conv_scheduler

Sequencing controller for the convolution datapath. It walks 1-D convolution windows over the IF scratchpad with a programmable stride and drives the IF and filter read addresses and the MAC enables/framing. It writes one partial sum per window to the psum scratchpad and stalls until producer write counts show the needed IF/filter words are present. It sits between the scratchpad write logic and the MAC/psum path.

## Interface
- IF_ADDRESS_SIZE, 8, IF/psum address MSB index (addresses are IF_ADDRESS_SIZE+1 bits)
- FILTER_ADDRESS_SIZE, 8, filter address MSB index
- STRIDE_SIZE, 2, stride MSB index (stride is STRIDE_SIZE+1 bits)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin job; sampled only in IDLE
- stride  in  STRIDE_SIZE+1  S, step between windows
- filter_size  in  3  F, taps per window
- if_size  in  3  N, IF words in the row
- if_base / psum_base  in  IF_ADDRESS_SIZE+1  IF row / psum start addresses
- filter_base  in  FILTER_ADDRESS_SIZE+1  filter start address
- if_avail  in  IF_ADDRESS_SIZE+1  IF words written so far from if_base (monotonic during a job)
- filter_avail  in  FILTER_ADDRESS_SIZE+1  filter words written so far
- if_rd_addr  out  IF_ADDRESS_SIZE+1  IF read address
- filter_rd_addr  out  FILTER_ADDRESS_SIZE+1  filter read address
- mac_en / mac_first / mac_last  out  1  tap valid / tap 0 (clear accumulator) / tap F-1
- psum_wr_en  out  1  write accumulated window result
- psum_wr_addr  out  IF_ADDRESS_SIZE+1  psum_base + window index
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky invalid-config flag; cleared on next accepted start

## Operation
- States: IDLE, LOAD, WAIT, MAC, WRITE, DONE.
- IDLE: start=1 latches stride, sizes and bases; clears win_off, win_idx, tap and err. Next state is LOAD.
- LOAD: if F=0, N=0, S=0 or F>N, set err and go to DONE. Otherwise go to WAIT.
- WAIT: go to MAC when if_avail ≥ win_off+F and filter_avail ≥ F; otherwise hold.
- MAC: F cycles, tap 0..F-1, with mac_en=1.
  - if_rd_addr = if_base+win_off+tap
  - filter_rd_addr = filter_base+tap
  - mac_first when tap=0, mac_last when tap=F-1
- WRITE: psum_wr_en=1 for one cycle with psum_wr_addr=psum_base+win_idx.
  - If win_off+S+F > N, go to DONE.
  - Otherwise win_off += S, win_idx += 1, go to WAIT.
- DONE: done=1 for one cycle, then IDLE. start is ignored in every state except IDLE.
- Arithmetic: offset sums use 5-bit internal width (max 7+7+7=21, no overflow). Comparisons zero-extend to IF_ADDRESS_SIZE+1 bits. Read and psum addresses wrap modulo 2^(width).
- Window count is (N-F)/S+1, computed iteratively with no divider. Example: N=7, F=3, S=2 gives offsets 0, 2, 4.
- Invalid config produces no mac_en and no psum_wr_en.

## Timing
- All outputs are registered. At reset all outputs are 0, state is IDLE, and counters are 0.
- Cycle of start sampled = t. LOAD at t+1, WAIT at t+2, first mac_en at t+3 if data is already available.
- Per window, minimum F+2 cycles (WAIT, F×MAC, WRITE). done rises the cycle after the last WRITE.
- Invalid config: done at t+2 with err=1.
- Reset mid-job: immediate return to IDLE, all outputs 0, and no done pulse.
- if_avail/filter_avail increasing during MAC has no effect. Readiness is evaluated only in WAIT.

## Configuration
- CONV_SCHED_STALL_CNT_EN
  - Defined: adds output stall_cycles [15:0], which counts cycles spent in WAIT without advancing. It clears on accepted start, saturates at 0xFFFF, and is 0 at reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package conv_sched_pkg holds:
  - the state enum (IDLE..DONE)
  - the 5-bit offset width localparam
  - the config-validity function
- One sub-module, conv_sched_addr_gen. It holds win_off, win_idx and tap, and forms the three addresses and the last-window / last-tap flags. The FSM stays in the top.

## Test plan
- N=7, F=3, S=2, bases 0, avail full, start → 3 windows; if_rd_addr 0,1,2 / 2,3,4 / 4,5,6; psum_wr_addr 0,1,2; done at t+2+15.
- N=5, F=3, S=1, if_avail=2, raised to 5 after 10 cycles → stays in WAIT until if_avail ≥3, window 1 proceeds once ≥4; 3 psum writes; stall_cycles=10 with macro defined.
- F=0, or F=5 with N=4 → err=1, done at t+2, zero mac_en and zero psum_wr_en.
- if_base=510, IF_ADDRESS_SIZE=8, N=F=3, S=1 → if_rd_addr 510, 511, 0; one psum write.
- rst_n low during the second MAC tap → all outputs 0 asynchronously; after release, new start runs normally.
- start pulsed while busy and in the DONE cycle → ignored; exactly one job completes.
